// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: operands captured on start, product after WIDTH+1 cycles.
// Unsigned or two's-complement per operation; signed operands are reduced to magnitudes first.
module seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 tc,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 neg_q, neg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       sum;

    // The most-negative operand negates to itself, which is its correct unsigned magnitude.
    assign mag_a = (tc && A[WIDTH-1]) ? -A : A;
    assign mag_b = (tc && B[WIDTH-1]) ? -B : B;

    // Upper-half add keeps the carry so the following right shift does not lose it.
    assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        p_d      = p_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    mcand_d  = mag_a;
                    mplier_d = mag_b;
                    neg_d    = tc & (A[WIDTH-1] ^ B[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                // After the last bit one extra RUN cycle applies the sign and loads P.
                if (cnt_q != CW'(WIDTH)) begin
                    acc_d    = {sum, acc_q[WIDTH-1:1]};
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end else begin
                    p_d     = neg_q ? -acc_q : acc_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
        end
    end

    assign P    = p_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: WIDTH=4 directed vectors and WIDTH=8 random operations,
// checked every cycle against a transaction-level model plus literal product checks.
module tb_seq_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, st4, tc4, st8, tc8;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic [7:0]  p4;
    logic [15:0] p8;
    logic        busy4, done4, busy8, done8;

    seq_mult #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .start(st4), .tc(tc4), .A(a4), .B(b4),
                              .P(p4), .busy(busy4), .done(done4));
    seq_mult #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(st8), .tc(tc8), .A(a8), .B(b8),
                              .P(p8), .busy(busy8), .done(done8));

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int dn4      = 0;

    function automatic longint ref_prod(input int w, input bit t, input longint a, input longint b);
        longint m;
        m = (longint'(1) << (2 * w)) - 1;
        if (t) begin
            if (a >= (longint'(1) << (w - 1))) a -= (longint'(1) << w);
            if (b >= (longint'(1) << (w - 1))) b -= (longint'(1) << w);
        end
        return (a * b) & m;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Model: an accepted start begins an operation lasting WIDTH+2 cycles; P updates
    // to the exact product on the last of them (the done cycle) and holds otherwise.
    int     ph4 = 0, ph8 = 0;
    longint lat4 = 0, lat8 = 0, exp4 = 0, exp8 = 0;

    always @(posedge clk) begin
        if (rst) begin
            ph4 <= 0; exp4 <= 0;
            ph8 <= 0; exp8 <= 0;
        end else begin
            if (ph4 == 0) begin
                if (st4) begin ph4 <= 1; lat4 <= ref_prod(4, tc4, a4, b4); end
            end else if (ph4 == 6) ph4 <= 0;
            else begin
                ph4 <= ph4 + 1;
                if (ph4 == 5) exp4 <= lat4;
            end
            if (ph8 == 0) begin
                if (st8) begin ph8 <= 1; lat8 <= ref_prod(8, tc8, a8, b8); end
            end else if (ph8 == 10) ph8 <= 0;
            else begin
                ph8 <= ph8 + 1;
                if (ph8 == 9) exp8 <= lat8;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy4", busy4, ph4 != 0);
            chk("done4", done4, ph4 == 6);
            chk("P4",    p4,    exp4);
            chk("busy8", busy8, ph8 != 0);
            chk("done8", done8, ph8 == 10);
            chk("P8",    p8,    exp8);
            if (done4 === 1'b1) dn4++;
        end
    end

    task automatic run4(input bit t, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp, input string nm, output int lat);
        tc4 = t; a4 = a; b4 = b; st4 = 1'b1;
        @(negedge clk);
        st4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); tc4 = 1'($urandom);
        lat = 0;
        while (done4 !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        chk({nm, "_done"}, done4, 1'b1);
        chk(nm, p4, exp);
        @(negedge clk);
    endtask

    task automatic run8(input bit t, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string nm);
        int lat;
        lat = 0;
        while (busy8 !== 1'b0 && lat < 20) begin @(negedge clk); lat++; end
        chk({nm, "_idle"}, busy8, 1'b0);
        tc8 = t; a8 = a; b8 = b; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); tc8 = 1'($urandom);
        lat = 0;
        while (done8 !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        chk({nm, "_lat"}, lat, 9);
        chk(nm, p8, exp);
        // Occasionally poke start during the done cycle; it must be ignored.
        if ($urandom_range(0, 3) == 0) st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
    endtask

    initial begin
        int lat, d0;
        rst = 1'b1; st4 = 1'b0; tc4 = 1'b0; a4 = '0; b4 = '0;
        st8 = 1'b0; tc8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_P4", p4, 8'h00);
        chk("rst_busy4", busy4, 1'b0);
        chk("rst_done4", done4, 1'b0);
        chk("rst_P8", p8, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        run4(1'b0, 4'd5,  4'd4,  8'h14, "u5x4", lat);
        chk("lat_u5x4", lat, 5);
        run4(1'b0, 4'd15, 4'd15, 8'hE1, "u15x15", lat);
        run4(1'b0, 4'd0,  4'd9,  8'h00, "u0x9", lat);
        run4(1'b1, 4'b1101, 4'b0101, 8'hF1, "s-3x5", lat);
        run4(1'b1, 4'b1000, 4'b1000, 8'h40, "s-8x-8", lat);
        run4(1'b1, 4'b0111, 4'b1000, 8'hC8, "s7x-8", lat);

        // Starts while busy (mid-run and in the done cycle) are ignored.
        d0 = dn4;
        tc4 = 1'b0; a4 = 4'd3; b4 = 4'd3; st4 = 1'b1;
        @(negedge clk); st4 = 1'b0;
        @(negedge clk);
        a4 = 4'd7; b4 = 4'd7; st4 = 1'b1;
        @(negedge clk); st4 = 1'b0;
        lat = 0;
        while (done4 !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        a4 = 4'd7; b4 = 4'd7; st4 = 1'b1;
        @(negedge clk); st4 = 1'b0;
        repeat (10) @(negedge clk);
        chk("ign_dones", dn4 - d0, 1);
        chk("ign_P", p4, 8'h09);

        // Start held high for several cycles launches a single operation.
        d0 = dn4;
        a4 = 4'd2; b4 = 4'd2; st4 = 1'b1;
        repeat (4) @(negedge clk);
        st4 = 1'b0;
        repeat (10) @(negedge clk);
        chk("held_dones", dn4 - d0, 1);
        chk("held_P", p4, 8'h04);

        // Reset mid-operation aborts with no done pulse.
        d0 = dn4;
        a4 = 4'd6; b4 = 4'd6; st4 = 1'b1;
        @(negedge clk); st4 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_P", p4, 8'h00);
        chk("abort_busy", busy4, 1'b0);
        repeat (8) @(negedge clk);
        chk("abort_dones", dn4 - d0, 0);
        run4(1'b0, 4'd2, 4'd3, 8'h06, "u2x3", lat);

        run8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u255x255");
        run8(1'b1, 8'h80, 8'h80, 16'h4000, "s-128x-128");
        run8(1'b1, 8'h7F, 8'h80, 16'hC080, "s127x-128");
        for (int i = 0; i < 1000; i++) begin
            logic       t;
            logic [7:0] a, b;
            t = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            run8(t, a, b, 16'(ref_prod(8, t, a, b)), "rand8");
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
